// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM states, Speed codes and
// the tick period selected by each Speed code.
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SPD_1CYC = 2'b00;
  localparam logic [1:0] SPD_F    = 2'b01;
  localparam logic [1:0] SPD_2F   = 2'b10;
  localparam logic [1:0] SPD_4F   = 2'b11;

  // Tick period in clock cycles for a Speed code, given the clock frequency.
  function automatic int unsigned period_of(input logic [1:0] spd, input int unsigned freq);
    int unsigned p;
    case (spd)
      SPD_1CYC: p = 1;
      SPD_F:    p = freq;
      SPD_2F:   p = 2 * freq;
      SPD_4F:   p = 4 * freq;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// Control/status bundle of the count sequencer.
interface count_sequencer_if;
  logic       Start;
  logic       Stop;
  logic       Step;
  logic [1:0] Speed;
  logic [3:0] Limit;
  logic       Mode;
  logic [3:0] CounterValue;
  logic       Running;
  logic       Tick;
  logic       Done;

  modport master (
    output Start, Stop, Step, Speed, Limit, Mode,
    input  CounterValue, Running, Tick, Done
  );

  modport slave (
    input  Start, Stop, Step, Speed, Limit, Mode,
    output CounterValue, Running, Tick, Done
  );
endinterface

// File: rtl/seq_rate_tick.sv
// Programmable down-counting divider; tick flags the zero phase.
module seq_rate_tick #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         hold,
  input  logic [W:0]   period,
  output logic         tick
);

  logic [W-1:0] div_q;
  logic [W-1:0] reload;

  assign reload = W'(period - (W+1)'(1));
  assign tick   = (div_q == '0);

  // Load restarts a full period; otherwise count down and wrap at zero unless held.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (load) begin
      div_q <= reload;
    end else if (!hold) begin
      div_q <= (div_q == '0) ? reload : div_q - W'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Start/stop/step controlled 4-bit counter advancing at a selectable rate,
// with one-shot or wrapping terminal behaviour.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Step,
  input  logic [1:0] Speed,
  input  logic [3:0] Limit,
  input  logic       Mode,
  output logic [3:0] CounterValue,
  output logic       Running,
  output logic       Tick,
  output logic       Done
);

  localparam int unsigned DIV_W = $clog2(4 * CLOCK_FREQUENCY);
  localparam int unsigned PW    = DIV_W + 1;

  state_e        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [1:0]    speed_q, speed_d;
  logic          running_q;
  logic          done_q, done_d;
  logic          load_d;
  logic          adv_d;
  logic          tick_raw;
  logic [1:0]    speed_sel;
  logic [PW-1:0] period_w;

  // A fresh start loads the divider from the incoming Speed, not the latched one.
  assign speed_sel = load_d ? Speed : speed_q;
  assign period_w  = PW'(period_of(speed_sel, CLOCK_FREQUENCY));

  seq_rate_tick #(.W(DIV_W)) u_rate (
    .clk    (ClockIn),
    .rst    (Reset),
    .load   (load_d),
    .hold   ((state_q != ST_RUN) || Stop),
    .period (period_w),
    .tick   (tick_raw)
  );

  // Next-state: Stop beats Start beats Step; any advance then applies terminal rules.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    speed_d = speed_q;
    done_d  = 1'b0;
    load_d  = 1'b0;
    adv_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Stop) begin
          state_d = ST_IDLE;
        end else if (Start) begin
          state_d = ST_RUN;
          count_d = '0;
          speed_d = Speed;
          load_d  = 1'b1;
        end else if (Step) begin
          adv_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          state_d = ST_PAUSE;
        end else if (tick_raw) begin
          adv_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (Stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (Start) begin
          state_d = ST_RUN;
        end else if (Step) begin
          adv_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (Stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (Start) begin
          state_d = ST_RUN;
          count_d = '0;
          speed_d = Speed;
          load_d  = 1'b1;
        end
      end
    endcase
    if (adv_d) begin
      if (count_q == Limit) begin
        done_d = 1'b1;
        if (Mode) begin
          count_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      speed_q   <= SPD_1CYC;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      speed_q   <= speed_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= done_d;
    end
  end

  assign CounterValue = count_q;
  assign Running      = running_q;
  assign Done         = done_q;
  assign Tick         = (state_q == ST_RUN) && tick_raw;

endmodule

// File: tb/tb_count_sequencer.sv
// Randomized and directed bench for count_sequencer with a timeline-based model.
module tb_count_sequencer;

  localparam int F = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  count_sequencer_if ifc ();

  count_sequencer #(.CLOCK_FREQUENCY(F)) dut (
    .ClockIn      (clk),
    .Reset        (rst),
    .Start        (ifc.Start),
    .Stop         (ifc.Stop),
    .Step         (ifc.Step),
    .Speed        (ifc.Speed),
    .Limit        (ifc.Limit),
    .Mode         (ifc.Mode),
    .CounterValue (ifc.CounterValue),
    .Running      (ifc.Running),
    .Tick         (ifc.Tick),
    .Done         (ifc.Done)
  );

  // Model: state label, count, period in cycles, and RUN edges elapsed since the
  // last fresh start; advances fall on every P-th RUN edge of that timeline.
  int m_st    = M_IDLE;
  int m_cnt   = 0;
  int m_per   = 1;
  int m_phase = 0;
  int m_done  = 0;

  function automatic int per_of(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return F;
      2'd2: return 2 * F;
      default: return 4 * F;
    endcase
  endfunction

  function automatic int exp_tick();
    return (m_st == M_RUN && (m_phase % m_per) == m_per - 1) ? 1 : 0;
  endfunction

  function automatic void model_step();
    int adv;
    int tick_now;
    adv = 0;
    if (rst) begin
      m_st = M_IDLE; m_cnt = 0; m_done = 0; m_per = 1; m_phase = 0;
    end else begin
      tick_now = exp_tick();
      m_done = 0;
      if (m_st == M_RUN) begin
        if (ifc.Stop) m_st = M_PAUSE;
        else begin
          adv = tick_now;
          m_phase++;
        end
      end else if (ifc.Stop) begin
        if (m_st != M_IDLE) begin m_st = M_IDLE; m_cnt = 0; end
      end else if (ifc.Start) begin
        if (m_st == M_PAUSE) m_st = M_RUN;
        else begin
          m_st = M_RUN; m_cnt = 0; m_per = per_of(ifc.Speed); m_phase = 0;
        end
      end else if (ifc.Step && m_st != M_DONE) begin
        adv = 1;
      end
      if (adv != 0) begin
        if (m_cnt == int'(ifc.Limit)) begin
          m_done = 1;
          if (ifc.Mode) m_cnt = 0;
          else m_st = M_DONE;
        end else begin
          m_cnt = (m_cnt + 1) % 16;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change only at negedge+1, so at negedge they still hold the values
  // the DUT sampled on the preceding rising edge.
  always @(negedge clk) begin
    model_step();
    chk("mdl_count",   int'(ifc.CounterValue), m_cnt);
    chk("mdl_running", int'(ifc.Running), (m_st == M_RUN) ? 1 : 0);
    chk("mdl_tick",    int'(ifc.Tick), exp_tick());
    chk("mdl_done",    int'(ifc.Done), m_done);
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic go_idle();
    rst = 1'b1;
    ifc.Start = 1'b0; ifc.Stop = 1'b0; ifc.Step = 1'b0;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    int first;
    ifc.Start = 1'b1; ifc.Stop = 1'b0; ifc.Step = 1'b0;
    ifc.Speed = 2'b00; ifc.Limit = 4'd0; ifc.Mode = 1'b0;

    // Reset with Start held, then release.
    repeat (3) nxt();
    chk("rst_count", int'(ifc.CounterValue), 0);
    chk("rst_running", int'(ifc.Running), 0);
    chk("rst_tick", int'(ifc.Tick), 0);
    chk("rst_done", int'(ifc.Done), 0);
    rst = 1'b0; ifc.Start = 1'b0;
    nxt();
    chk("post_rst_running", int'(ifc.Running), 0);

    // P=4, Limit=3, wrap: 1,2,3,0 at edges 4,8,12,16; Done only after edge 16.
    go_idle();
    ifc.Speed = 2'b01; ifc.Limit = 4'd3; ifc.Mode = 1'b1; ifc.Start = 1'b1;
    nxt();
    ifc.Start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      nxt();
      chk("wrap_count", int'(ifc.CounterValue), (k / 4) % 4);
      chk("wrap_done", int'(ifc.Done), (k == 16) ? 1 : 0);
    end

    // P=1, Limit=2, one-shot.
    go_idle();
    ifc.Speed = 2'b00; ifc.Limit = 4'd2; ifc.Mode = 1'b0; ifc.Start = 1'b1;
    nxt();
    ifc.Start = 1'b0;
    chk("os_tick0", int'(ifc.Tick), 1);
    nxt(); chk("os_count1", int'(ifc.CounterValue), 1);
    nxt(); chk("os_count2", int'(ifc.CounterValue), 2);
    nxt();
    chk("os_done", int'(ifc.Done), 1);
    chk("os_running", int'(ifc.Running), 0);
    chk("os_hold", int'(ifc.CounterValue), 2);
    nxt();
    chk("os_done_pulse", int'(ifc.Done), 0);
    chk("os_hold2", int'(ifc.CounterValue), 2);

    // P=8, pause at edge 3, resume keeps the remaining period and ignores Speed.
    go_idle();
    ifc.Speed = 2'b10; ifc.Limit = 4'd15; ifc.Mode = 1'b0; ifc.Start = 1'b1;
    nxt();
    ifc.Start = 1'b0;
    nxt();
    nxt();
    ifc.Stop = 1'b1;
    nxt();
    ifc.Stop = 1'b0;
    chk("pause_running", int'(ifc.Running), 0);
    repeat (10) nxt();
    ifc.Start = 1'b1; ifc.Speed = 2'b00;
    nxt();
    ifc.Start = 1'b0;
    first = 0;
    for (int j = 1; j <= 8; j++) begin
      nxt();
      if (ifc.Tick && first == 0) first = j;
    end
    chk("resume_tick_delay", first, 5);
    chk("resume_count", int'(ifc.CounterValue), 1);

    // Start+Stop in IDLE, Step in PAUSE, Step during RUN.
    go_idle();
    ifc.Start = 1'b1; ifc.Stop = 1'b1;
    nxt();
    ifc.Start = 1'b0; ifc.Stop = 1'b0;
    chk("startstop_idle", int'(ifc.Running), 0);
    ifc.Speed = 2'b01; ifc.Limit = 4'd15; ifc.Mode = 1'b0; ifc.Start = 1'b1;
    nxt();
    ifc.Start = 1'b0; ifc.Stop = 1'b1;
    nxt();
    ifc.Stop = 1'b0; ifc.Step = 1'b1;
    nxt();
    ifc.Step = 1'b0;
    chk("pause_step_count", int'(ifc.CounterValue), 1);
    chk("pause_step_running", int'(ifc.Running), 0);
    ifc.Start = 1'b1;
    nxt();
    ifc.Start = 1'b0; ifc.Step = 1'b1;
    nxt();
    ifc.Step = 1'b0;
    chk("run_step_ignored", int'(ifc.CounterValue), 1);
    chk("run_step_running", int'(ifc.Running), 1);

    // Limit=0 with wrap: every advance terminal.
    go_idle();
    ifc.Speed = 2'b00; ifc.Limit = 4'd0; ifc.Mode = 1'b1; ifc.Start = 1'b1;
    nxt();
    ifc.Start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      nxt();
      chk("lim0_done", int'(ifc.Done), 1);
      chk("lim0_count", int'(ifc.CounterValue), 0);
    end

    // Reset mid-RUN at count 2.
    go_idle();
    ifc.Speed = 2'b00; ifc.Limit = 4'd15; ifc.Mode = 1'b1; ifc.Start = 1'b1;
    nxt();
    ifc.Start = 1'b0;
    nxt();
    nxt();
    chk("midrun_count", int'(ifc.CounterValue), 2);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk("midrun_rst_count", int'(ifc.CounterValue), 0);
    chk("midrun_rst_running", int'(ifc.Running), 0);
    chk("midrun_rst_tick", int'(ifc.Tick), 0);
    chk("midrun_rst_done", int'(ifc.Done), 0);
    for (int k = 0; k < 5; k++) begin
      nxt();
      chk("midrun_no_tick", int'(ifc.Tick), 0);
    end

    // Random phase, checked by the model on every cycle.
    for (int i = 0; i < 4000; i++) begin
      nxt();
      rst       = ($urandom_range(0, 99) == 0);
      ifc.Start = ($urandom_range(0, 9) == 0);
      ifc.Stop  = ($urandom_range(0, 14) == 0);
      ifc.Step  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        ifc.Speed = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      end
      if ($urandom_range(0, 19) == 0) ifc.Limit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) ifc.Mode = 1'($urandom_range(0, 1));
    end
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
